uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Receive front-end of the APB UART. Sits between the RX pin and the RX FIFO write port.
- Generates its own fractional 16x-oversampling tick from the clock-divider register fields.
- Synchronises RX, detects start bits, majority-samples each bit and checks the stop bit.
- Hands completed bytes downstream on a valid/ready handshake, with frame-error, break and overrun flags for the status register.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- SYNC_STAGES, 2, number of RX synchroniser flops (minimum 2).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset
- rx_en  in  1  receiver enable (control register RX_EN)
- div_int  in  16  integer part of oversample tick period, in PCLK cycles
- div_frac  in  4  fractional part of tick period, in 1/16 PCLK cycles
- RX  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received byte (holding register)
- rx_valid  out  1  rx_data valid; drives RX FIFO wr_en together with rx_ready
- rx_ready  in  1  downstream accepts (RX FIFO not full)
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- break_det  out  1  one-cycle pulse: break condition detected
- overrun  out  1  one-cycle pulse: completed byte dropped
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: reset is PRESETn, asynchronous, active-low; clock is PCLK.
- Output reset values: rx_data=0, rx_valid=0, all pulses 0, busy=0. State=IDLE, synchroniser flops=1, tick counter and accumulator=0.
- Tick generator:
  - 4-bit accumulator; on each tick, acc<=acc+div_frac.
  - Carry out makes the next tick period div_int+1 cycles, otherwise div_int cycles.
  - The tick is a one-cycle enable.
  - div_int==0 means no ticks.
  - div_int==1 with div_frac==0 gives a tick every cycle.
  - A new divider value takes effect on the next tick.
- rx_en=0: FSM forced to IDLE; tick counter and accumulator cleared; rx_data and rx_valid hold.
- Synchronised RX (rx_s) is used everywhere; RX-to-rx_s latency is SYNC_STAGES cycles.
- FSM states are IDLE, START, DATA, STOP and BRK. Each bit spans 16 ticks, numbered 0..15.
  - IDLE: on a tick with rx_s==0, go to START with tick count=0 (this tick is tick 0).
  - Sampling: rx_s is sampled at ticks 7, 8 and 9; the bit value is the 2-of-3 majority, decided at tick 9.
  - START: majority 1 means a false start, return to IDLE at tick 9. Otherwise continue to tick 15, then go to DATA with bit index 0.
  - DATA: DATA_BITS bits, LSB first, shifted into a shift register. After the last bit's tick 15, go to STOP.
  - STOP, majority 1: frame good; return to IDLE at tick 9 so the next start edge can resync early.
  - STOP, majority 0 with any data bit 1: frame_err pulse, byte discarded, return to IDLE.
  - STOP, majority 0 with all data bits 0: frame_err and break_det pulse together; go to BRK.
  - BRK: stay until rx_s==1 on a tick, then return to IDLE.
- Delivery, on a good frame (the cycle after the stop decision):
  - rx_valid==0: load rx_data and set rx_valid.
  - rx_valid==1 && rx_ready==1 in that cycle: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid==1 && rx_ready==0: new byte dropped, overrun pulse, rx_data unchanged.
- Handshake: the transfer occurs on a cycle with rx_valid && rx_ready. rx_valid then clears unless a new byte loads in the same cycle. rx_data is stable while rx_valid && !rx_ready.
- Reset mid-frame: immediate return to the reset state; a partial byte is lost with no flag.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds inputs parity_en (1) and parity_odd (1), output parity_err (1, pulse, reset 0), and a PARITY state between DATA and STOP.
  - With parity_en=1, the parity bit is majority-sampled like data.
  - On mismatch: parity_err pulse at the stop decision and the byte is discarded.
  - On mismatch with stop=0, frame_err also pulses.
  - With parity_en=0, frames are the same as the undefined case.
- Undefined: no parity ports or state; the frame is always 8N1.

Test Plan:
- div_int=4, div_frac=0, rx_ready=1, send 8N1 0xA5 → rx_valid 1-cycle pulse with rx_data=0xA5, 612..620 cycles after RX falls; no flags.
- Same divider, 3-cycle RX low glitch while idle → false start, no rx_valid, busy returns to 0 within 40 cycles.
- rx_ready=0, send 0x11 then 0x22 → rx_data holds 0x11, overrun pulses once at the second stop decision; rx_ready=1 then drains 0x11.
- Send 0x3C with stop bit forced 0 → frame_err pulse, no rx_valid. Hold RX low for 12 bit times → frame_err+break_det, busy=1 until RX high, then 0x55 received correctly.
- div_int=3, div_frac=8: ticks alternate periods 3 and 4 (acc sequence 8,0,8,0…); a 0xF0 frame at the matching baud is received; PRESETn pulse mid-frame gives no output and the next frame is received correctly.
- UART_RX_PARITY_EN, parity_en=1, parity_odd=0, send 0x07 with parity bit 0 → parity_err pulse, no rx_valid; with parity bit 1 → rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive front-end: fractional 16x tick, RX synchroniser, majority-sampling
// frame FSM and valid/ready byte delivery. Optional parity: define UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 rx_en,
    input  logic [15:0]          div_int,
    input  logic [3:0]           div_frac,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 parity_err
`endif
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ---- stage p0: synchroniser and tick generator ----
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [15:0]            tick_cyc;
    logic [3:0]             acc;
    logic                   carry;
    logic [16:0]            period;
    logic                   tick;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    // A carry out of the fractional accumulator stretches the following period by one cycle.
    assign period = {1'b0, div_int} + {16'd0, carry};
    assign tick   = rx_en && (div_int != 16'd0) && (({1'b0, tick_cyc} + 17'd1) >= period);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tick_cyc <= 16'd0;
            acc      <= 4'd0;
            carry    <= 1'b0;
        end else if (!rx_en) begin
            tick_cyc <= 16'd0;
            acc      <= 4'd0;
            carry    <= 1'b0;
        end else if (tick) begin
            tick_cyc     <= 16'd0;
            {carry, acc} <= {1'b0, acc} + {1'b0, div_frac};
        end else if (div_int != 16'd0) begin
            tick_cyc <= tick_cyc + 16'd1;
        end
    end

    // ---- stage p0: frame FSM ----
    state_t                 state, state_nxt;
    logic [3:0]             tick_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   samp7, samp8;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   maj;
    logic                   par_bad;
    logic                   good_p0, ferr_p0, brk_p0, perr_p0;

    assign maj = maj3(samp7, samp8, rx_s);

`ifdef UART_RX_PARITY_EN
    logic par_q;
    assign par_bad = parity_en && (par_q != ((^shift_q) ^ parity_odd));
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!rx_en) begin
            state_nxt = IDLE;
        end else if (tick) begin
            case (state)
                IDLE:  if (!rx_s) state_nxt = START;
                START: begin
                    if (tick_cnt == 4'd9 && maj) state_nxt = IDLE;
                    else if (tick_cnt == 4'd15)  state_nxt = DATA;
                end
                DATA: begin
                    if (tick_cnt == 4'd15 && bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = parity_en ? PARITY : STOP;
`else
                        state_nxt = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick_cnt == 4'd15) state_nxt = STOP;
`endif
                STOP: begin
                    if (tick_cnt == 4'd9)
                        state_nxt = (!maj && shift_q == '0) ? BRK : IDLE;
                end
                BRK:     if (rx_s) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        good_p0 = 1'b0;
        ferr_p0 = 1'b0;
        brk_p0  = 1'b0;
        perr_p0 = 1'b0;
        busy    = (state != IDLE);
        if (tick && state == STOP && tick_cnt == 4'd9) begin
            good_p0 = maj && !par_bad;
            ferr_p0 = !maj;
            brk_p0  = !maj && (shift_q == '0);
            perr_p0 = par_bad;
        end
    end

    // The IDLE tick that sees the start edge is tick 0, so the next one is tick 1.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tick_cnt <= 4'd0;
            bit_idx  <= '0;
        end else if (!rx_en) begin
            tick_cnt <= 4'd0;
            bit_idx  <= '0;
        end else if (tick) begin
            tick_cnt <= (state == IDLE) ? 4'd1 : tick_cnt + 4'd1;
            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && tick_cnt == 4'd15)
                bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (tick) begin
            if (tick_cnt == 4'd7) samp7 <= rx_s;
            if (tick_cnt == 4'd8) samp8 <= rx_s;
            if (state == DATA && tick_cnt == 4'd9)
                shift_q <= {maj, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && tick_cnt == 4'd9)
                par_q <= maj;
`endif
        end
    end

    // ---- stage p1: delivery holding register and status pulses ----
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= ferr_p0;
            break_det  <= brk_p0;
            overrun    <= good_p0 && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_p0;
`endif
            if (good_p0 && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_perr;
    assign unused_perr = perr_p0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer; parity scenario built when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        rx_en = 1'b0;
    logic [15:0] div_int = 16'd4;
    logic [3:0]  div_frac = 4'd0;
    logic        RX = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, break_det, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        parity_err;
`endif

    int total = 0;
    int bad = 0;

    uart_rx_deserializer #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .rx_en(rx_en), .div_int(div_int), .div_frac(div_frac),
        .RX(RX), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .break_det(break_det), .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
        , .parity_en(parity_en), .parity_odd(parity_odd), .parity_err(parity_err)
`endif
    );

    always #5 PCLK = ~PCLK;

    // Event monitor sampled on the falling edge
    int         cyc = 0;
    int         n_xfer = 0, n_vcyc = 0, n_ferr = 0, n_brk = 0, n_ovr = 0, n_perr = 0;
    int         first_vcyc = 0;
    logic [7:0] last_xfer = 8'h00;
    logic       v_prev = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (rx_valid && rx_ready) begin
            n_xfer    <= n_xfer + 1;
            last_xfer <= rx_data;
        end
        if (rx_valid) n_vcyc <= n_vcyc + 1;
        if (rx_valid && !v_prev) first_vcyc <= cyc;
        v_prev <= rx_valid;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (break_det) n_brk <= n_brk + 1;
        if (overrun)   n_ovr <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr <= n_perr + 1;
`endif
    end

    task automatic drive_bit(input logic b, input int n);
        RX = b;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bpc,
                              input int use_par, input logic pbit);
        drive_bit(1'b0, bpc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bpc);
        if (use_par != 0) drive_bit(pbit, bpc);
        drive_bit(stop_bit, bpc);
        RX = 1'b1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        rx_en   = 1'b0;
        repeat (3) @(negedge PCLK);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ({frame_err, break_det, overrun} !== 3'b000)
            begin bad++; $display("FAIL reset_pulses got=%03b exp=000", {frame_err, break_det, overrun}); end
        PRESETn = 1'b1;
        rx_en   = 1'b1;
        repeat (5) @(negedge PCLK);
    endtask

    task automatic test_basic();
        int s_x, s_v, s_f, s_b, s_o, t0, lat;
        s_x = n_xfer; s_v = n_vcyc; s_f = n_ferr; s_b = n_brk; s_o = n_ovr;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 64, 0, 1'b0);
        repeat (128) @(negedge PCLK);
        lat = first_vcyc - t0;
        total++; if (n_xfer - s_x !== 1) begin bad++; $display("FAIL basic_xfer got=%0d exp=1", n_xfer - s_x); end
        total++; if (last_xfer !== 8'hA5) begin bad++; $display("FAIL basic_data got=%0h exp=a5", last_xfer); end
        total++; if (n_vcyc - s_v !== 1) begin bad++; $display("FAIL basic_valid_width got=%0d exp=1", n_vcyc - s_v); end
        total++; if (lat < 612 || lat > 620) begin bad++; $display("FAIL basic_latency got=%0d exp=612..620", lat); end
        total++; if (n_ferr - s_f + n_brk - s_b + n_ovr - s_o !== 0)
            begin bad++; $display("FAIL basic_flags got=%0d exp=0", n_ferr - s_f + n_brk - s_b + n_ovr - s_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_glitch();
        int s_x, s_f;
        s_x = n_xfer; s_f = n_ferr;
        RX = 1'b0;
        repeat (3) @(negedge PCLK);
        RX = 1'b1;
        repeat (42) @(negedge PCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%0b exp=0", busy); end
        repeat (100) @(negedge PCLK);
        total++; if (n_xfer - s_x !== 0) begin bad++; $display("FAIL glitch_xfer got=%0d exp=0", n_xfer - s_x); end
        total++; if (n_ferr - s_f !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - s_f); end
    endtask

    task automatic test_overrun();
        int s_o, s_x;
        s_o = n_ovr; s_x = n_xfer;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 64, 0, 1'b0);
        repeat (64) @(negedge PCLK);
        send_frame(8'h22, 1'b1, 64, 0, 1'b0);
        repeat (128) @(negedge PCLK);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_hold_data got=%0h exp=11", rx_data); end
        total++; if (n_ovr - s_o !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - s_o); end
        total++; if (n_xfer - s_x !== 0) begin bad++; $display("FAIL ovr_no_xfer got=%0d exp=0", n_xfer - s_x); end
        rx_ready = 1'b1;
        @(negedge PCLK);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_drain_data got=%0h exp=11", rx_data); end
        repeat (10) @(negedge PCLK);
    endtask

    task automatic test_frame_err();
        int s_x, s_f, s_b;
        s_x = n_xfer; s_f = n_ferr; s_b = n_brk;
        send_frame(8'h3C, 1'b0, 64, 0, 1'b0);
        repeat (192) @(negedge PCLK);
        total++; if (n_ferr - s_f !== 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - s_f); end
        total++; if (n_brk - s_b !== 0) begin bad++; $display("FAIL ferr_no_break got=%0d exp=0", n_brk - s_b); end
        total++; if (n_xfer - s_x !== 0) begin bad++; $display("FAIL ferr_no_xfer got=%0d exp=0", n_xfer - s_x); end
    endtask

    task automatic test_break();
        int s_x, s_f, s_b;
        s_x = n_xfer; s_f = n_ferr; s_b = n_brk;
        RX = 1'b0;
        repeat (11 * 64) @(negedge PCLK);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL brk_busy_low got=%0b exp=1", busy); end
        repeat (64) @(negedge PCLK);
        RX = 1'b1;
        repeat (64) @(negedge PCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL brk_busy_release got=%0b exp=0", busy); end
        total++; if (n_ferr - s_f !== 1) begin bad++; $display("FAIL brk_ferr got=%0d exp=1", n_ferr - s_f); end
        total++; if (n_brk - s_b !== 1) begin bad++; $display("FAIL brk_pulse got=%0d exp=1", n_brk - s_b); end
        send_frame(8'h55, 1'b1, 64, 0, 1'b0);
        repeat (128) @(negedge PCLK);
        total++; if (n_xfer - s_x !== 1) begin bad++; $display("FAIL brk_next_xfer got=%0d exp=1", n_xfer - s_x); end
        total++; if (last_xfer !== 8'h55) begin bad++; $display("FAIL brk_next_data got=%0h exp=55", last_xfer); end
    endtask

    task automatic test_frac();
        int times[5];
        int k, guard, d1, d2, d3, d4, s_x, s_f;
        div_int  = 16'd3;
        div_frac = 4'd8;
        repeat (20) @(negedge PCLK);
        k = 0; guard = 0;
        while (k < 5 && guard < 100) begin
            if (dut.tick) begin times[k] = cyc; k++; end
            @(negedge PCLK);
            guard++;
        end
        total++; if (k !== 5) begin bad++; $display("FAIL frac_tick_count got=%0d exp=5", k); end
        d1 = times[1] - times[0]; d2 = times[2] - times[1];
        d3 = times[3] - times[2]; d4 = times[4] - times[3];
        total++; if (!((d1 == 3 && d2 == 4) || (d1 == 4 && d2 == 3)) || d3 != d1 || d4 != d2)
            begin bad++; $display("FAIL frac_periods got=%0d,%0d,%0d,%0d exp=alternating 3/4", d1, d2, d3, d4); end
        s_x = n_xfer; s_f = n_ferr;
        send_frame(8'hF0, 1'b1, 56, 0, 1'b0);
        repeat (112) @(negedge PCLK);
        total++; if (n_xfer - s_x !== 1) begin bad++; $display("FAIL frac_xfer got=%0d exp=1", n_xfer - s_x); end
        total++; if (last_xfer !== 8'hF0) begin bad++; $display("FAIL frac_data got=%0h exp=f0", last_xfer); end
        total++; if (n_ferr - s_f !== 0) begin bad++; $display("FAIL frac_ferr got=%0d exp=0", n_ferr - s_f); end
    endtask

    task automatic test_reset_mid_frame();
        int s_x, s_f;
        s_x = n_xfer; s_f = n_ferr;
        drive_bit(1'b0, 56);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 56);
        PRESETn = 1'b0;
        RX = 1'b1;
        @(negedge PCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        PRESETn = 1'b1;
        repeat (3 * 56) @(negedge PCLK);
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00)
            begin bad++; $display("FAIL midrst_output got=%0b/%0h exp=0/00", rx_valid, rx_data); end
        total++; if (n_xfer - s_x !== 0) begin bad++; $display("FAIL midrst_no_xfer got=%0d exp=0", n_xfer - s_x); end
        send_frame(8'h3A, 1'b1, 56, 0, 1'b0);
        repeat (112) @(negedge PCLK);
        total++; if (n_xfer - s_x !== 1) begin bad++; $display("FAIL midrst_next_xfer got=%0d exp=1", n_xfer - s_x); end
        total++; if (last_xfer !== 8'h3A) begin bad++; $display("FAIL midrst_next_data got=%0h exp=3a", last_xfer); end
        total++; if (n_ferr - s_f !== 0) begin bad++; $display("FAIL midrst_ferr got=%0d exp=0", n_ferr - s_f); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int s_x, s_p;
        div_int    = 16'd4;
        div_frac   = 4'd0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        repeat (20) @(negedge PCLK);
        s_x = n_xfer; s_p = n_perr;
        send_frame(8'h07, 1'b1, 64, 1, 1'b0);
        repeat (128) @(negedge PCLK);
        total++; if (n_perr - s_p !== 1) begin bad++; $display("FAIL par_bad_pulse got=%0d exp=1", n_perr - s_p); end
        total++; if (n_xfer - s_x !== 0) begin bad++; $display("FAIL par_bad_xfer got=%0d exp=0", n_xfer - s_x); end
        s_p = n_perr;
        send_frame(8'h07, 1'b1, 64, 1, 1'b1);
        repeat (128) @(negedge PCLK);
        total++; if (n_xfer - s_x !== 1) begin bad++; $display("FAIL par_good_xfer got=%0d exp=1", n_xfer - s_x); end
        total++; if (last_xfer !== 8'h07) begin bad++; $display("FAIL par_good_data got=%0h exp=07", last_xfer); end
        total++; if (n_perr - s_p !== 0) begin bad++; $display("FAIL par_good_pulse got=%0d exp=0", n_perr - s_p); end
        parity_en = 1'b0;
    endtask
`endif

    initial begin
        @(negedge PCLK);
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_break();
        test_frac();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
